// File: rtl/noise_gen_param_pkg.sv
// -----------------------------------------------------------------------------
// noise_gen_param_pkg
// Shared definitions for the parametrised noise source:
//   - noise_mode_e : output mode encodings (white S&H, slew, binary, mute)
//   - TAPS_DEFAULT / SEED_DEFAULT_C : default 16-bit Galois tap mask and seed
//   - period_limit() : maps a programmed period to the terminal count value
// -----------------------------------------------------------------------------
package noise_gen_param_pkg;

    typedef enum logic [1:0] {
        MODE_WHITE = 2'd0,
        MODE_SLEW  = 2'd1,
        MODE_BIN   = 2'd2,
        MODE_MUTE  = 2'd3
    } noise_mode_e;

    localparam int          LFSR_WIDTH_DEFAULT = 16;
    localparam logic [15:0] TAPS_DEFAULT       = 16'hB400;
    localparam logic [15:0] SEED_DEFAULT_C     = 16'h0001;

    // Periods 0 and 1 both mean "tick every cycle", so both map to a limit of 0.
    function automatic logic [31:0] period_limit(input logic [31:0] period);
        return (period < 32'd2) ? 32'd0 : (period - 32'd1);
    endfunction

endpackage

// File: rtl/noise_gen_param_lfsr_galois.sv
// -----------------------------------------------------------------------------
// lfsr_galois
// Right-shifting Galois LFSR with synchronous load and lock-up guard.
//   clk      : system clock
//   reset    : asynchronous active-low reset, loads SEED_DEFAULT
//   adv      : advance one step this cycle
//   load     : load load_val this cycle (has priority over adv)
//   load_val : seed value; an all-zero value is replaced by 1
//   q        : current LFSR state
// -----------------------------------------------------------------------------
module lfsr_galois
    import noise_gen_param_pkg::*;
#(
    parameter int                    LFSR_WIDTH   = LFSR_WIDTH_DEFAULT,
    parameter logic [LFSR_WIDTH-1:0] TAPS         = TAPS_DEFAULT,
    parameter logic [LFSR_WIDTH-1:0] SEED_DEFAULT = SEED_DEFAULT_C
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  adv,
    input  logic                  load,
    input  logic [LFSR_WIDTH-1:0] load_val,
    output logic [LFSR_WIDTH-1:0] q
);

    localparam logic [LFSR_WIDTH-1:0] ONE = LFSR_WIDTH'(1);

    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [LFSR_WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            // An all-zero state would never leave zero, so substitute 1.
            lfsr_d = (load_val == '0) ? ONE : load_val;
        end else if (adv) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED_DEFAULT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/noise_gen_param.sv
// -----------------------------------------------------------------------------
// noise_gen_param
// Parametrised noise source for the voice mixer. A Galois LFSR runs on clk; a
// programmable period counter produces a one-cycle sample strobe, and on each
// strobe the output is refreshed according to the selected mode.
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   en          : run enable; low freezes counter, LFSR and output
//   period      : sample period in clk cycles (0 and 1 = every cycle)
//   mode        : 0 white S&H, 1 slew, 2 binary, 3 mute (midscale)
//   seed        : LFSR seed used by seed_load
//   seed_load   : one-cycle seed strobe; restarts the period, suppresses tick
//   value       : registered noise sample
//   sample_tick : one-cycle strobe coincident with each sample update
// -----------------------------------------------------------------------------
module noise_gen_param
    import noise_gen_param_pkg::*;
#(
    parameter int                    WIDTH        = 8,
    parameter int                    LFSR_WIDTH   = LFSR_WIDTH_DEFAULT,
    parameter logic [LFSR_WIDTH-1:0] TAPS         = TAPS_DEFAULT,
    parameter logic [LFSR_WIDTH-1:0] SEED_DEFAULT = SEED_DEFAULT_C,
    parameter int                    SLEW_STEP    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [31:0]           period,
    input  logic [1:0]            mode,
    input  logic [LFSR_WIDTH-1:0] seed,
    input  logic                  seed_load,
    output logic [WIDTH-1:0]      value,
    output logic                  sample_tick
);

    localparam logic [WIDTH-1:0] MIDSCALE = WIDTH'(1) << (WIDTH - 1);

    logic [LFSR_WIDTH-1:0] lfsr_q;

    logic [31:0]      cnt_q,    cnt_d;
    logic [WIDTH-1:0] value_q,  value_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             tick_q,   tick_d;
    noise_mode_e      mode_q,   mode_d;

    noise_mode_e      mode_in;
    logic [31:0]      lim;
    logic             tick_now;
    logic             slew_active;
    logic [WIDTH-1:0] sample_bits;

    // Move cur toward tgt by at most SLEW_STEP. Done one bit wider so the
    // upward sum cannot wrap before it is clamped at the target.
    function automatic logic [WIDTH-1:0] slew_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] tgt);
        logic [WIDTH:0] c;
        logic [WIDTH:0] t;
        logic [WIDTH:0] s;
        logic [WIDTH:0] sum;
        c   = {1'b0, cur};
        t   = {1'b0, tgt};
        s   = (WIDTH + 1)'(SLEW_STEP);
        sum = c + s;
        if (c < t) begin
            return (sum > t) ? tgt : sum[WIDTH-1:0];
        end else if (c > t) begin
            return ((c - t) > s) ? (cur - s[WIDTH-1:0]) : tgt;
        end
        return cur;
    endfunction

    lfsr_galois #(
        .LFSR_WIDTH  (LFSR_WIDTH),
        .TAPS        (TAPS),
        .SEED_DEFAULT(SEED_DEFAULT)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .adv     (en && !seed_load),
        .load    (seed_load),
        .load_val(seed),
        .q       (lfsr_q)
    );

    // Only the low WIDTH bits of the LFSR feed the sample.
    generate
        if (WIDTH < LFSR_WIDTH) begin : g_unused_hi
            logic unused_lfsr_hi;
            assign unused_lfsr_hi = ^lfsr_q[LFSR_WIDTH-1:WIDTH];
        end
    endgenerate

    assign mode_in     = noise_mode_e'(mode);
    assign lim         = period_limit(period);
    assign sample_bits = lfsr_q[WIDTH-1:0];

    // >= rather than == so a period shortened below the current count ticks
    // on the next cycle instead of running on through 2^32.
    assign tick_now    = en && !seed_load && (cnt_q >= lim);

    // Slewing needs mode 1 both latched at the last tick and still selected,
    // so switching away from mode 1 halts the ramp without waiting for a tick.
    assign slew_active = (mode_q == MODE_SLEW) && (mode_in == MODE_SLEW);

    always_comb begin
        cnt_d    = cnt_q;
        value_d  = value_q;
        target_d = target_q;
        tick_d   = 1'b0;
        mode_d   = mode_q;
        if (seed_load) begin
            cnt_d = '0;
        end else if (en) begin
            if (tick_now) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                mode_d = mode_in;
                case (mode_in)
                    MODE_WHITE: value_d  = sample_bits;
                    MODE_SLEW:  target_d = sample_bits;
                    MODE_BIN:   value_d  = {WIDTH{lfsr_q[0]}};
                    MODE_MUTE:  value_d  = MIDSCALE;
                    default:    value_d  = value_q;
                endcase
            end else begin
                cnt_d = cnt_q + 32'd1;
                if (slew_active) begin
                    value_d = slew_toward(value_q, target_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            value_q  <= '0;
            target_q <= '0;
            tick_q   <= 1'b0;
            mode_q   <= MODE_WHITE;
        end else begin
            cnt_q    <= cnt_d;
            value_q  <= value_d;
            target_q <= target_d;
            tick_q   <= tick_d;
            mode_q   <= mode_d;
        end
    end

    assign value       = value_q;
    assign sample_tick = tick_q;

endmodule

// File: tb/tb_noise_gen_param.sv
// -----------------------------------------------------------------------------
// tb_noise_gen_param
// Scoreboard bench for noise_gen_param. The driver applies one input vector per
// clock, advances a behavioural model of the noise source and queues the state
// expected after that edge; an independent monitor pops and compares after
// every edge. Directed sequences are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_noise_gen_param;

    localparam int W    = 8;
    localparam int LW   = 16;
    localparam int STEP = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [31:0]   period = '0;
    logic [1:0]    mode = '0;
    logic [LW-1:0] seed = '0;
    logic          seed_load = 1'b0;
    logic [W-1:0]  value;
    logic          sample_tick;

    always #5 clk = ~clk;

    noise_gen_param #(
        .WIDTH    (W),
        .LFSR_WIDTH(LW),
        .SLEW_STEP(STEP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .period     (period),
        .mode       (mode),
        .seed       (seed),
        .seed_load  (seed_load),
        .value      (value),
        .sample_tick(sample_tick)
    );

    typedef struct {
        logic [W-1:0]  value;
        logic          tick;
        logic [LW-1:0] lfsr;
        logic [31:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: the noise source described directly by its rules.
    int unsigned m_lfsr, m_cnt, m_value, m_target, m_mode;
    bit          m_tick;

    function automatic void model_reset();
        m_lfsr = 1; m_cnt = 0; m_value = 0; m_target = 0; m_mode = 0; m_tick = 0;
    endfunction

    function automatic void model_step();
        longint lim;
        int     mv, tv;
        if (seed_load) begin
            m_lfsr = (seed == 0) ? 1 : int'(seed);
            m_cnt  = 0;
            m_tick = 0;
        end else if (en) begin
            lim = (period < 2) ? 0 : longint'(period) - 1;
            if (longint'(m_cnt) >= lim) begin
                m_tick = 1;
                m_cnt  = 0;
                m_mode = mode;
                case (mode)
                    2'd0: m_value  = m_lfsr % 256;
                    2'd1: m_target = m_lfsr % 256;
                    2'd2: m_value  = (m_lfsr % 2 == 1) ? 255 : 0;
                    default: m_value = 128;
                endcase
            end else begin
                m_tick = 0;
                m_cnt  = m_cnt + 1;
                if (m_mode == 1 && mode == 2'd1) begin
                    mv = int'(m_value);
                    tv = int'(m_target);
                    if (mv < tv)      mv = (mv + STEP > tv) ? tv : mv + STEP;
                    else if (mv > tv) mv = (mv - STEP < tv) ? tv : mv - STEP;
                    m_value = mv;
                end
            end
            m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 32'hB400) : (m_lfsr / 2);
        end else begin
            m_tick = 0;
        end
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    task automatic step(input logic e, input logic [31:0] p, input logic [1:0] md,
                        input logic sl, input logic [LW-1:0] sd);
        exp_t x;
        @(posedge clk);
        #2;
        reset     = 1'b1;
        en        = e;
        period    = p;
        mode      = md;
        seed_load = sl;
        seed      = sd;
        model_step();
        x.value = W'(m_value);
        x.tick  = m_tick;
        x.lfsr  = LW'(m_lfsr);
        x.cnt   = m_cnt;
        exp_q.push_back(x);
    endtask

    // Asserts reset between clock edges and checks the outputs straight away.
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset     = 1'b0;
        en        = 1'b0;
        seed_load = 1'b0;
        model_reset();
        #1;
        chk("reset_value", 32'(value), 32'h0);
        chk("reset_tick", 32'(sample_tick), 32'h0);
        chk("reset_lfsr", 32'(dut.u_lfsr.q), 32'h0001);
        repeat (2) @(posedge clk);
    endtask

    // Monitor: the DUT presents a new state after every edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n_cmp++;
                if (value !== x.value || sample_tick !== x.tick ||
                    dut.u_lfsr.q !== x.lfsr || dut.cnt_q !== x.cnt) begin
                    n_bad++;
                    $display("FAIL scoreboard t=%0t value act=%h req=%h tick act=%b req=%b lfsr act=%h req=%h cnt act=%0d req=%0d",
                             $time, value, x.value, sample_tick, x.tick,
                             dut.u_lfsr.q, x.lfsr, dut.cnt_q, x.cnt);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cur_period;
        logic [1:0]  cur_mode;

        do_reset();

        // Seed 1, white mode, every cycle: 01,00,00,00,80.
        step(1'b0, 32'd1, 2'd0, 1'b1, 16'h0001);
        repeat (5) step(1'b1, 32'd1, 2'd0, 1'b0, '0);

        // Asynchronous reset in the middle of a run.
        step(1'b1, 32'd3, 2'd0, 1'b0, '0);
        do_reset();

        // Period 4, cut to 2 while the count sits at 3, then period 0.
        repeat (3) step(1'b1, 32'd4, 2'd0, 1'b0, '0);
        repeat (6) step(1'b1, 32'd2, 2'd0, 1'b0, '0);
        repeat (4) step(1'b1, 32'd0, 2'd0, 1'b0, '0);
        // Huge period, then cut down mid-count.
        repeat (5) step(1'b1, 32'hFFFF_FFFF, 2'd0, 1'b0, '0);
        repeat (3) step(1'b1, 32'd3, 2'd0, 1'b0, '0);

        // Slew up from 0 to 0x80 in steps of 16, then hold.
        do_reset();
        step(1'b0, 32'd0, 2'd1, 1'b1, 16'h0080);
        step(1'b1, 32'd0, 2'd1, 1'b0, '0);
        repeat (12) step(1'b1, 32'd100, 2'd1, 1'b0, '0);
        // Leave mode 1 mid-ramp toward a new target.
        step(1'b1, 32'd0, 2'd1, 1'b0, '0);
        repeat (2) step(1'b1, 32'd100, 2'd1, 1'b0, '0);
        repeat (3) step(1'b1, 32'd100, 2'd0, 1'b0, '0);

        // Seed load on a tick cycle, then a zero seed.
        step(1'b1, 32'd0, 2'd0, 1'b1, 16'h1234);
        step(1'b1, 32'd0, 2'd0, 1'b1, 16'h0000);
        repeat (2) step(1'b1, 32'd0, 2'd0, 1'b0, '0);

        // Freeze mid-period, then mute and binary.
        repeat (2) step(1'b1, 32'd5, 2'd0, 1'b0, '0);
        repeat (10) step(1'b0, 32'd5, 2'd0, 1'b0, '0);
        repeat (6) step(1'b1, 32'd5, 2'd3, 1'b0, '0);
        repeat (20) step(1'b1, 32'd2, 2'd2, 1'b0, '0);

        // Randomized run.
        cur_period = 3;
        cur_mode   = 2'd1;
        repeat (3000) begin
            if ($urandom_range(0, 49) == 0)
                cur_period = ($urandom_range(0, 3) == 0) ? $urandom_range(7, 40) : $urandom_range(0, 6);
            if ($urandom_range(0, 24) == 0)
                cur_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0)
                do_reset();
            else
                step($urandom_range(0, 7) != 0, cur_period, cur_mode,
                     $urandom_range(0, 39) == 0, 16'($urandom));
        end

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
